// File: rtl/mag_sort_pkg.sv
// mag_sort_pkg -- shared definitions for the mag_sort_ctrl batch sorter.
//   state_t        : FSM state encodings (LOAD, SORT, DRAIN)
//   DEFAULT_WIDTH  : default data word width
//   DEFAULT_N      : default number of words per sort batch
package mag_sort_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned DEFAULT_N     = 4;

endpackage

// File: rtl/mag_comp.sv
// mag_comp -- combinational unsigned magnitude comparator.
// Ports:
//   A, B   : input  [WIDTH-1:0] operands (unsigned)
//   EQ     : output A == B
//   GT     : output A >  B
//   LT     : output A <  B
// Exactly one of EQ/GT/LT is high for any operand pair.
module mag_comp #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             EQ,
    output logic             GT,
    output logic             LT
);

    always_comb begin
        EQ = (A == B);
        GT = (A > B);
        LT = (A < B);
    end

endmodule

// File: rtl/mag_sort_ctrl.sv
// mag_sort_ctrl -- loads a batch of N unsigned words, bubble-sorts them in
// place one compare per cycle through a single shared mag_comp, then drains
// them in ascending order.
// Ports:
//   clk        : input  clock, rising edge
//   rst        : input  asynchronous active-high reset
//   in_valid   : input  in_data carries a word for loading
//   in_ready   : output block accepts a word this cycle (LOAD state)
//   in_data    : input  [WIDTH-1:0] word to load
//   out_valid  : output out_data carries a sorted word (DRAIN state)
//   out_ready  : input  consumer accepts out_data this cycle
//   out_data   : output [WIDTH-1:0] sorted word, ascending
//   busy       : output high while sorting
// Build option:
//   MAG_SORT_EARLY_EXIT_EN : when defined, a pass without any swap ends the
//                            sort early; otherwise SORT lasts (N-1)^2 cycles.
module mag_sort_ctrl
    import mag_sort_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned N     = DEFAULT_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int unsigned CW = $clog2(N) + 1;
    localparam int unsigned AW = $clog2(N);
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
    localparam logic [CW-1:0] LAST_J   = CW'(N - 2);
    localparam logic [CW-1:0] ONE      = CW'(1);

    state_t state, state_next;

    logic [CW-1:0]    idx, j, p;
    logic [WIDTH-1:0] slots [N];

    logic [AW-1:0] idx_ix, j_ix, j1_ix;
    logic          cmp_eq, cmp_gt, cmp_lt;
    logic          swap;
    logic          load_fire, drain_fire, pass_end, sort_end;

`ifdef MAG_SORT_EARLY_EXIT_EN
    logic swap_flag;
`endif

    // Counters carry one spare bit; only the low bits address the slots.
    assign idx_ix = idx[AW-1:0];
    assign j_ix   = j[AW-1:0];
    assign j1_ix  = j_ix + AW'(1);

    mag_comp #(.WIDTH(WIDTH)) u_comp (
        .A  (slots[j_ix]),
        .B  (slots[j1_ix]),
        .EQ (cmp_eq),
        .GT (cmp_gt),
        .LT (cmp_lt)
    );

    // Swap only on a strict GT so equal words keep their order (stable).
    assign swap = (state == SORT) && cmp_gt && !(cmp_eq || cmp_lt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        out_data   = '0;
        load_fire  = 1'b0;
        drain_fire = 1'b0;
        pass_end   = 1'b0;
        sort_end   = 1'b0;
        case (state)
            LOAD: begin
                in_ready  = 1'b1;
                load_fire = in_valid;
                if (in_valid && idx == LAST_IDX) state_next = SORT;
            end
            SORT: begin
                busy     = 1'b1;
                pass_end = (j == LAST_J);
`ifdef MAG_SORT_EARLY_EXIT_EN
                // The current compare counts toward this pass's swap record.
                sort_end = pass_end && ((p == LAST_J) || !(swap_flag || swap));
`else
                sort_end = pass_end && (p == LAST_J);
`endif
                if (sort_end) state_next = DRAIN;
            end
            DRAIN: begin
                out_valid  = 1'b1;
                out_data   = slots[idx_ix];
                drain_fire = out_ready;
                if (out_ready && idx == LAST_IDX) state_next = LOAD;
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
            j   <= '0;
            p   <= '0;
            for (int unsigned i = 0; i < N; i++) slots[i] <= '0;
`ifdef MAG_SORT_EARLY_EXIT_EN
            swap_flag <= 1'b0;
`endif
        end else begin
            case (state)
                LOAD: begin
                    if (load_fire) begin
                        slots[idx_ix] <= in_data;
                        idx           <= (idx == LAST_IDX) ? '0 : idx + ONE;
                    end
                end
                SORT: begin
                    if (swap) begin
                        slots[j_ix]  <= slots[j1_ix];
                        slots[j1_ix] <= slots[j_ix];
                    end
                    if (pass_end) begin
                        j <= '0;
                        p <= sort_end ? '0 : p + ONE;
                    end else begin
                        j <= j + ONE;
                    end
`ifdef MAG_SORT_EARLY_EXIT_EN
                    swap_flag <= pass_end ? 1'b0 : (swap_flag | swap);
`endif
                end
                DRAIN: begin
                    if (drain_fire) idx <= (idx == LAST_IDX) ? '0 : idx + ONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mag_sort_ctrl.sv
// tb_mag_sort_ctrl -- scoreboard bench for mag_sort_ctrl (WIDTH=4, N=4).
// Expected sorted words are queued when a batch is issued; a monitor pops
// and compares on every out_valid & out_ready cycle.
module tb_mag_sort_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = 4'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] out_data;
    logic       busy;

    int tests = 0;
    int fails = 0;
    logic [3:0] exp_q [$];
    logic [3:0] mon_exp;

`ifdef MAG_SORT_EARLY_EXIT_EN
    localparam int LAT_A = 9, LAT_B = 3, LAT_C = 3, LAT_D = 9, LAT_E = 6;
`else
    localparam int LAT_A = 9, LAT_B = 9, LAT_C = 9, LAT_D = 9, LAT_E = 9;
`endif

    mag_sort_ctrl #(.WIDTH(4), .N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL out_data: got %0d expected nothing (queue empty)", out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("out_data", int'(out_data), int'(mon_exp));
            end
        end
    end

    // Words and expectations are listed left to right: index 3 is first.
    task automatic run_batch(input string tag, input logic [3:0][3:0] w,
                             input logic [3:0][3:0] e, input int exp_lat,
                             input bit hold, input bit junk);
        int lat;
        bit sort_bad;
        bit back;
        out_ready = !hold;
        for (int i = 3; i >= 0; i--) begin
            in_valid = 1'b1;
            in_data  = w[i];
            @(posedge clk); #1;
        end
        for (int i = 3; i >= 0; i--) exp_q.push_back(e[i]);
        in_valid = junk;
        in_data  = 4'd14;
        lat = 0;
        sort_bad = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = k;
                break;
            end
            if (!busy || in_ready) sort_bad = 1'b1;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy/in_ready in sort"}, int'(sort_bad), 0);
        if (hold) begin
            for (int k = 0; k < 5; k++) begin
                check({tag, " hold out_valid"}, int'(out_valid), 1);
                check({tag, " hold out_data"}, int'(out_data), int'(e[3]));
                if (junk) check({tag, " in_ready in drain"}, int'(in_ready), 0);
                @(posedge clk); #1;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        back = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (in_ready && !out_valid) begin
                back = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check({tag, " return to load"}, int'(back), 1);
    endtask

    initial begin
        bit leak;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", int'(out_valid), 0);
        check("reset out_data", int'(out_data), 0);
        check("reset busy", int'(busy), 0);
        check("reset in_ready", int'(in_ready), 1);
        rst = 1'b0;
        @(posedge clk); #1;

        run_batch("mixed",   {4'd5, 4'd12, 4'd3, 4'd10}, {4'd3, 4'd5, 4'd10, 4'd12}, LAT_A, 1'b0, 1'b0);
        run_batch("sorted",  {4'd1, 4'd2, 4'd3, 4'd4},   {4'd1, 4'd2, 4'd3, 4'd4},   LAT_B, 1'b0, 1'b0);
        run_batch("equal",   {4'd7, 4'd7, 4'd7, 4'd7},   {4'd7, 4'd7, 4'd7, 4'd7},   LAT_C, 1'b0, 1'b0);
        run_batch("extreme", {4'd15, 4'd0, 4'd15, 4'd0}, {4'd0, 4'd0, 4'd15, 4'd15}, LAT_D, 1'b1, 1'b0);

        // Abort a batch with reset in the fourth SORT cycle.
        for (int i = 3; i >= 0; i--) begin
            in_valid = 1'b1;
            in_data  = 4'(9 - (3 - i));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midsort rst out_valid", int'(out_valid), 0);
        check("midsort rst out_data", int'(out_data), 0);
        check("midsort rst busy", int'(busy), 0);
        check("midsort rst in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        leak = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (out_valid || busy) leak = 1'b1;
        end
        check("no output after abort", int'(leak), 0);

        run_batch("after rst", {4'd2, 4'd1, 4'd4, 4'd3}, {4'd1, 4'd2, 4'd3, 4'd4}, LAT_E, 1'b0, 1'b0);
        run_batch("junk in",   {4'd5, 4'd12, 4'd3, 4'd10}, {4'd3, 4'd5, 4'd10, 4'd12}, LAT_A, 1'b1, 1'b1);

        repeat (2) @(posedge clk);
        check("scoreboard drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mag_sort_ctrl.md
MAG_SORT_CTRL -- requirements
Module: mag_sort_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bit width of each data word.
REQ-002 SHALL have parameter N, default 4, legal range 2..16: number of words per sort batch.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  in_data carries a word for loading.
REQ-006 SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  unsigned word to load.
REQ-008 SHALL have port out_valid  output  1  out_data carries a sorted word.
REQ-009 SHALL have port out_ready  input  1  consumer accepts out_data this cycle.
REQ-010 SHALL have port out_data  output  WIDTH  sorted word, ascending order.
REQ-011 SHALL have port busy  output  1  high while state is SORT.

Function
REQ-012 SHALL implement FSM states LOAD, SORT and DRAIN; after reset the state is LOAD.
REQ-013 LOAD: in_ready=1; each in_valid&in_ready edge writes in_data to slot idx and increments idx; the N-th accept moves the state to SORT and clears idx.
REQ-014 SORT: in_ready=0, out_valid=0, busy=1; exactly one compare of slot j against slot j+1 per cycle through the single shared comparator.
REQ-015 SORT swaps slots j and j+1 only when slot j GT slot j+1; EQ leaves them unswapped, so the sort is stable.
REQ-016 j runs 0..N-2 per pass; pass p runs 0..N-2; after the final compare of pass N-2 the state moves to DRAIN.
REQ-017 Without early exit, SORT lasts exactly (N-1)^2 cycles; out_valid rises (N-1)^2 edges after the edge capturing the last input.
REQ-018 DRAIN: out_valid=1 and out_data=slot idx; each out_valid&out_ready edge increments idx; the N-th handshake moves the state to LOAD with idx=0.
REQ-019 With out_ready=0, out_data SHALL hold stable and the state SHALL not advance.
REQ-020 in_valid outside LOAD SHALL be ignored, with no storage change.
REQ-021 Comparison SHALL be unsigned over all WIDTH bits; idx/j/p counters sized $clog2(N)+1.

Reset
REQ-022 rst=1 SHALL immediately set state=LOAD, idx=j=p=0, all slots=0, out_valid=0, out_data=0, busy=0, in_ready=1.
REQ-023 rst asserted during SORT or DRAIN SHALL discard the batch; no partial output after release.

Configuration
REQ-024 With macro MAG_SORT_EARLY_EXIT_EN defined, a per-pass swap flag SHALL end SORT at the end of any pass with zero swaps (minimum N-1 cycles).
REQ-025 Without MAG_SORT_EARLY_EXIT_EN, the swap flag SHALL be absent and SORT length fixed per REQ-017.

Structure
REQ-026 Package mag_sort_pkg SHALL hold FSM state encodings (LOAD=2'd0, SORT=2'd1, DRAIN=2'd2) and the default WIDTH/N constants.
REQ-027 SHALL instantiate one combinational sub-module mag_comp (inputs A, B; outputs EQ, GT, LT) as the sole comparator.

Verification
REQ-028 N=4, WIDTH=4, load 5,12,3,10 -> output 3,5,10,12; out_valid high 9 edges after last accept (macro off).
REQ-029 Macro on, load 1,2,3,4 -> output 1,2,3,4; out_valid high 3 edges after last accept.
REQ-030 Load 7,7,7,7 -> output 7,7,7,7; no swaps performed; latency as REQ-028/REQ-029.
REQ-031 Load 15,0,15,0; hold out_ready=0 for 5 cycles in DRAIN -> out_data stays 0, out_valid stays 1; then 0,0,15,15.
REQ-032 Assert rst at SORT cycle 4 of batch 9,8,7,6 -> all outputs at reset values; next batch 2,1,4,3 -> 1,2,3,4.
REQ-033 Drive in_valid=1 throughout SORT/DRAIN with value 14 -> in_ready=0 and output unaffected.
